// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg
//   Shared constants and types for the RAM/IO responder: IO window decode,
//   IO register offsets, the status byte layout and an address decode helper.
//   No ports. Imported by ram_io_responder.
package ram_io_responder_pkg;

   // call_addr[17:16] == IO_SEL selects the IO window at 0x30000.
   localparam logic [1:0]  IO_SEL      = 2'b11;
   localparam logic [17:0] IO_BASE     = 18'h30000;
   localparam logic [15:0] IO_DATA_OFF = 16'h0000;  // UART TX push / RX pop
   localparam logic [15:0] IO_STAT_OFF = 16'h0004;  // status read / halt write

   typedef enum logic [1:0] {
      ACC_RAM,
      ACC_IO_DATA,
      ACC_IO_STAT,
      ACC_IO_NONE
   } acc_t;

   // Status byte: bit0 tx_empty, bit1 io_buffer_full, bit2 rx_full, bit3 ovf.
   typedef struct packed {
      logic [3:0] rsvd;
      logic       ovf;
      logic       rx_full;
      logic       buf_full;
      logic       tx_empty;
   } io_status_t;

   function automatic acc_t decode_access(input logic [17:0] addr);
      acc_t acc;
      if (addr[17:16] != IO_SEL)            acc = ACC_RAM;
      else if (addr[15:0] == IO_DATA_OFF)   acc = ACC_IO_DATA;
      else if (addr[15:0] == IO_STAT_OFF)   acc = ACC_IO_STAT;
      else                                  acc = ACC_IO_NONE;
      return acc;
   endfunction

endpackage

// File: rtl/ram_io_responder_io_tx_fifo.sv
// io_tx_fifo
//   Byte FIFO feeding the UART transmitter, with a registered almost-full
//   flag that asserts when at most MARGIN slots remain free.
//   Ports:
//     clk, rst_n    clock / async active-low reset
//     push, push_data  enqueue request and byte
//     pop_ready     consumer accepts head (pop when non-empty)
//     head          byte at the read pointer
//     not_empty     FIFO holds at least one byte
//     full          FIFO holds DEPTH bytes
//     almost_full   registered: count >= DEPTH-MARGIN
//     drop          push rejected this cycle (full and no pop)
module io_tx_fifo #(
   parameter int DEPTH  = 8,
   parameter int MARGIN = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop_ready,
   output logic [7:0] head,
   output logic       not_empty,
   output logic       full,
   output logic       almost_full,
   output logic       drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             pop;
   logic             accept;

   assign not_empty = (count != '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign pop       = not_empty & pop_ready;
   // A push on a full FIFO still lands when the head leaves in the same cycle.
   assign accept    = push & (~full | pop);
   assign drop      = push & full & ~pop;
   assign head      = store[rd_ptr];

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise a latch is inferred.
   always_comb begin
      count_next = count;
      case ({accept, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // NOTE: storage arrays are deliberately left out of reset; only pointers
   // and count define validity, and an unreset array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept) store[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         // Power-of-two depth: pointer overflow is the modulo wrap.
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count_next;
         almost_full <= (count_next >= CNT_W'(DEPTH - MARGIN));
      end
   end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder
//   Responder for the byte-wide MemCtrl bus. Low 2^RAM_ADDR_W bytes are
//   on-chip RAM (read-before-write, 1-cycle latency); 0x30000-0x30007 is IO:
//   0x30000 write = UART TX push, read = RX pop; 0x30004 write = halt with
//   exit code, read = status {4'b0, ovf, rx_full, io_buffer_full, tx_empty}.
//   Optional feature macro: RAM_IO_RX_EN (RX holding register).
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     rdy                 bus enable; low freezes bus-side state
//     call_addr, is_write, write_data   bus request
//     ret_data            read byte, one enabled cycle after the address
//     io_buffer_full      TX FIFO has <= FULL_MARGIN free slots
//     uart_tx_data/valid/ready   TX stream out of the FIFO
//     uart_rx_data/valid/ready   RX stream into the holding register
//     program_finish, exit_code  halt pulse and its code
module ram_io_responder
   import ram_io_responder_pkg::*;
#(
   parameter int RAM_ADDR_W  = 17,
   parameter int TXF_DEPTH   = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic [31:0] call_addr,
   input  logic        is_write,
   input  logic [7:0]  write_data,
   output logic [7:0]  ret_data,
   output logic        io_buffer_full,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready,
   output logic        program_finish,
   output logic [7:0]  exit_code
);

   acc_t                  acc;
   logic [RAM_ADDR_W-1:0] ram_idx;
   logic                  tx_push;
   logic                  tx_drop;
   logic                  tx_full;
   logic                  finish_wr;
   logic                  rx_consume;
   logic                  rx_full;
   logic [7:0]            rx_view;
   logic                  ovf;
   io_status_t            status;
   logic [7:0]            io_rd;
   logic [7:0]            ram_q;
   logic [7:0]            io_q;
   logic                  sel_ram;
   logic                  unused_addr;

   assign acc         = decode_access(call_addr[17:0]);
   assign ram_idx     = call_addr[RAM_ADDR_W-1:0];
   assign unused_addr = &{1'b0, call_addr[31:18]};

   assign tx_push    = rdy & is_write  & (acc == ACC_IO_DATA);
   assign finish_wr  = rdy & is_write  & (acc == ACC_IO_STAT);
   assign rx_consume = rdy & ~is_write & (acc == ACC_IO_DATA);

   // ---------------- RAM ----------------
   logic [7:0] mem [2**RAM_ADDR_W];

   // Read and write share the edge, so ram_q picks up the pre-write byte.
   always_ff @(posedge clk) begin
      if (rdy && acc == ACC_RAM) begin
         ram_q <= mem[ram_idx];
         if (is_write) mem[ram_idx] <= write_data;
      end
   end

   // ---------------- TX FIFO ----------------
   io_tx_fifo #(
      .DEPTH  (TXF_DEPTH),
      .MARGIN (FULL_MARGIN)
   ) u_tx_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (tx_push),
      .push_data   (write_data),
      .pop_ready   (uart_tx_ready),
      .head        (uart_tx_data),
      .not_empty   (uart_tx_valid),
      .full        (tx_full),
      .almost_full (io_buffer_full),
      .drop        (tx_drop)
   );

   // ---------------- RX holding register ----------------
`ifdef RAM_IO_RX_EN
   logic       rx_capture;
   logic [7:0] rx_byte;

   // Capture only into an empty holder, so a same-cycle consume returns the
   // previous register contents while the new byte stays held.
   assign rx_capture    = uart_rx_valid & ~rx_full;
   assign uart_rx_ready = ~rx_full;
   assign rx_view       = rx_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_full <= 1'b0;
         rx_byte <= 8'h00;
      end else begin
         if (rx_capture) rx_byte <= uart_rx_data;
         rx_full <= rx_capture | (rx_full & ~rx_consume);
      end
   end
`else
   logic unused_rx;

   assign rx_full       = 1'b0;
   assign rx_view       = 8'h00;
   assign uart_rx_ready = 1'b0;
   assign unused_rx     = &{1'b0, uart_rx_data, uart_rx_valid, rx_consume};
`endif

   // ---------------- IO registers ----------------
   always_comb begin
      status          = '0;
      status.ovf      = ovf;
      status.rx_full  = rx_full;
      status.buf_full = io_buffer_full;
      status.tx_empty = ~uart_tx_valid;
   end

   always_comb begin
      io_rd = 8'h00;
      case (acc)
         ACC_IO_DATA: io_rd = rx_view;
         ACC_IO_STAT: io_rd = status;
         default:     io_rd = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf            <= 1'b0;
         program_finish <= 1'b0;
         exit_code      <= 8'h00;
         io_q           <= 8'h00;
         sel_ram        <= 1'b0;
      end else begin
         ovf            <= ovf | tx_drop;
         program_finish <= finish_wr;
         if (finish_wr) exit_code <= write_data;
         if (rdy) begin
            io_q    <= io_rd;
            sel_ram <= (acc == ACC_RAM);
         end
      end
   end

   // sel_ram resets to the IO side so ret_data reads 0 out of reset while the
   // unreset RAM output register stays hidden.
   assign ret_data = sel_ram ? ram_q : io_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
//   Directed self-checking bench for ram_io_responder: RAM read-before-write
//   and latency, TX FIFO ordering/full/overflow, halt pulse, rdy gating,
//   RX holding register (either build) and asynchronous reset.
module tb_ram_io_responder;

`ifdef RAM_IO_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy;
   logic [31:0] call_addr;
   logic        is_write;
   logic [7:0]  write_data;
   logic [7:0]  ret_data;
   logic        io_buffer_full;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;
   logic        program_finish;
   logic [7:0]  exit_code;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_io_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .call_addr      (call_addr),
      .is_write       (is_write),
      .write_data     (write_data),
      .ret_data       (ret_data),
      .io_buffer_full (io_buffer_full),
      .uart_tx_data   (uart_tx_data),
      .uart_tx_valid  (uart_tx_valid),
      .uart_tx_ready  (uart_tx_ready),
      .uart_rx_data   (uart_rx_data),
      .uart_rx_valid  (uart_rx_valid),
      .uart_rx_ready  (uart_rx_ready),
      .program_finish (program_finish),
      .exit_code      (exit_code)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
      call_addr  = addr;
      write_data = data;
      is_write   = 1'b1;
      tick();
      is_write   = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr);
      call_addr = addr;
      is_write  = 1'b0;
      tick();
   endtask

   logic [7:0] drain_exp [8];

   initial begin
      rst_n         = 1'b0;
      rdy           = 1'b1;
      call_addr     = 32'h0;
      is_write      = 1'b0;
      write_data    = 8'h00;
      uart_tx_ready = 1'b0;
      uart_rx_data  = 8'h00;
      uart_rx_valid = 1'b0;
      #3;

      // Reset state
      check("rst_ret_data", ret_data, 8'h00);
      check("rst_buf_full", io_buffer_full, 1'b0);
      check("rst_tx_valid", uart_tx_valid, 1'b0);
      check("rst_finish", program_finish, 1'b0);
      check("rst_exit_code", exit_code, 8'h00);
      check("rst_rx_ready", uart_rx_ready, RX_EN);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // RAM: write then read, read-before-write, back-to-back
      bus_write(32'h0001_0010 & 32'h0000_0010, 8'hA5);
      bus_read(32'h0000_0010);
      check("ram_read_a5", ret_data, 8'hA5);
      bus_write(32'h0000_0010, 8'h5A);
      check("ram_rbw_old", ret_data, 8'hA5);
      bus_write(32'h0000_0020, 8'h11);
      bus_write(32'h0000_0021, 8'h22);
      bus_read(32'h0000_0020);
      check("ram_b2b_0", ret_data, 8'h11);
      bus_read(32'h0000_0021);
      check("ram_b2b_1", ret_data, 8'h22);
      bus_read(32'h0000_0010);
      check("ram_read_5a", ret_data, 8'h5A);

      // TX streaming with the UART always ready
      uart_tx_ready = 1'b1;
      bus_write(32'h0003_0000, 8'h48);
      check("tx_head_48", uart_tx_data, 8'h48);
      check("tx_valid_48", uart_tx_valid, 1'b1);
      bus_write(32'h0003_0000, 8'h69);
      check("tx_head_69", uart_tx_data, 8'h69);
      check("tx_valid_69", uart_tx_valid, 1'b1);
      bus_read(32'h0000_0000);
      check("tx_valid_drop", uart_tx_valid, 1'b0);

      // Fill with UART stalled: flag after the 6th push, overflow on the 9th
      uart_tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) bus_write(32'h0003_0000, 8'(i));
      check("buf_full_5", io_buffer_full, 1'b0);
      bus_write(32'h0003_0000, 8'h06);
      check("buf_full_6", io_buffer_full, 1'b1);
      bus_write(32'h0003_0000, 8'h07);
      bus_write(32'h0003_0000, 8'h08);
      bus_read(32'h0003_0004);
      check("stat_full_no_ovf", ret_data, 8'h02);
      bus_write(32'h0003_0000, 8'h09);
      bus_read(32'h0003_0004);
      check("stat_ovf", ret_data, 8'h0A);
      check("tx_head_after_ovf", uart_tx_data, 8'h01);

      // Simultaneous push and pop on a full FIFO
      uart_tx_ready = 1'b1;
      bus_write(32'h0003_0000, 8'h0A);
      uart_tx_ready = 1'b0;
      check("pp_buf_full", io_buffer_full, 1'b1);
      check("pp_head", uart_tx_data, 8'h02);
      drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      uart_tx_ready = 1'b1;
      call_addr     = 32'h0000_0000;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), {uart_tx_valid, uart_tx_data}, {1'b1, drain_exp[i]});
         tick();
      end
      check("drain_empty", uart_tx_valid, 1'b0);
      check("drain_buf_full", io_buffer_full, 1'b0);
      bus_read(32'h0003_0004);
      check("stat_drained", ret_data, 8'h09);
      uart_tx_ready = 1'b0;

      // Halt pulse
      bus_write(32'h0003_0004, 8'h37);
      check("finish_pulse_a", program_finish, 1'b1);
      check("exit_code_37", exit_code, 8'h37);
      bus_write(32'h0003_0004, 8'h00);
      check("finish_pulse_b", program_finish, 1'b1);
      check("exit_code_00", exit_code, 8'h00);
      bus_read(32'h0000_0021);
      check("finish_clear", program_finish, 1'b0);

      // rdy low: no pulse, no RAM write, ret_data holds
      rdy = 1'b0;
      bus_write(32'h0003_0004, 8'h55);
      check("rdy0_no_finish", program_finish, 1'b0);
      check("rdy0_exit_hold", exit_code, 8'h00);
      bus_write(32'h0000_0010, 8'hEE);
      bus_read(32'h0000_0020);
      check("rdy0_ret_hold", ret_data, 8'h22);
      rdy = 1'b1;
      bus_read(32'h0000_0010);
      check("rdy0_no_ram_wr", ret_data, 8'h5A);

      // RX holding register
      uart_rx_data  = 8'h3C;
      uart_rx_valid = 1'b1;
      tick();
      uart_rx_valid = 1'b0;
      check("rx_ready_full", uart_rx_ready, 1'b0);
      bus_read(32'h0003_0004);
      check("stat_rx", ret_data, RX_EN ? 8'h0D : 8'h09);
      bus_read(32'h0003_0000);
      check("rx_data", ret_data, RX_EN ? 8'h3C : 8'h00);
      check("rx_ready_back", uart_rx_ready, RX_EN);

      // Asynchronous reset mid-transaction
      bus_write(32'h0003_0000, 8'h11);
      bus_write(32'h0003_0000, 8'h22);
      check("pre_rst_valid", uart_tx_valid, 1'b1);
      call_addr  = 32'h0003_0000;
      write_data = 8'h99;
      is_write   = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("arst_tx_valid", uart_tx_valid, 1'b0);
      check("arst_ret_data", ret_data, 8'h00);
      tick();
      is_write = 1'b0;
      rst_n    = 1'b1;
      tick();
      check("arst_lost_byte", uart_tx_valid, 1'b0);
      bus_read(32'h0003_0004);
      check("arst_stat", ret_data, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
